// File: rtl/queue_client_if.sv
// Bundle of the stream and queue-command signals around queue_client.
// master = queue_client side, slave = surrounding logic (parser, queue, strategy).
interface queue_client_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              q_write;
   logic              q_pop;
   logic              q_peek;
   logic [DATA_W-1:0] q_write_value;
   logic [DATA_W-1:0] q_read_value;
   logic [CNT_W-1:0]  count;

   modport master (
      input  in_valid, in_data, out_ready, q_read_value,
      output in_ready, out_valid, out_data, q_write, q_pop, q_peek, q_write_value, count
   );

   modport slave (
      output in_valid, in_data, out_ready, q_read_value,
      input  in_ready, out_valid, out_data, q_write, q_pop, q_peek, q_write_value, count
   );
endinterface

// File: rtl/queue_client.sv
// Initiator for the flag-less queue: tracks occupancy, feeds upstream words in, drains the head downstream.
// Build option QUEUE_CLIENT_PEEK_EN: peek at issue and pop only after downstream accepts the word.
module queue_client #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 16,
   parameter int READ_LAT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   queue_client_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef QUEUE_CLIENT_PEEK_EN
   localparam bit PEEK_EN = 1'b1;
`else
   localparam bit PEEK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RD_WAIT, HOLD} state_e;

   state_e            state_q, state_d;
   logic [2:0]        lat_q, lat_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              q_write_q, q_write_d;
   logic [DATA_W-1:0] q_write_value_q, q_write_value_d;
   logic              q_pop_q, q_pop_d;
   logic              q_peek_q, q_peek_d;

   logic read_issue;
   logic handshake;
   logic in_ready;
   logic accept;
   logic count_dec;

   assign handshake  = out_valid_q && bus.out_ready;
   assign read_issue = (state_q == IDLE) && !out_valid_q && (count_q != '0);

   // With peek, a write accepted on the handshake would land on the pop strobe; block it and the pop cycle.
   assign in_ready  = rst_n && (count_q < CNT_W'(DEPTH)) && !read_issue &&
                      !(PEEK_EN && (handshake || q_pop_q));
   assign accept    = bus.in_valid && in_ready;
   assign count_dec = PEEK_EN ? handshake : read_issue;

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
      state_d         = state_q;
      lat_d           = lat_q;
      count_d         = count_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      q_write_d       = accept;
      q_write_value_d = accept ? bus.in_data : q_write_value_q;
      q_pop_d         = 1'b0;
      q_peek_d        = 1'b0;

      if (accept)         count_d = count_q + 1'b1;
      else if (count_dec) count_d = count_q - 1'b1;

      unique case (state_q)
         IDLE: begin
            if (read_issue) begin
               state_d  = RD_WAIT;
               lat_d    = 3'(READ_LAT - 1);
               q_pop_d  = !PEEK_EN;
               q_peek_d = PEEK_EN;
            end
         end
         RD_WAIT: begin
            if (lat_q == '0) begin
               out_data_d  = bus.q_read_value;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         HOLD: begin
            if (handshake) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               q_pop_d     = PEEK_EN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q         <= IDLE;
         lat_q           <= '0;
         count_q         <= '0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         q_write_q       <= 1'b0;
         q_write_value_q <= '0;
         q_pop_q         <= 1'b0;
         q_peek_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         lat_q           <= lat_d;
         count_q         <= count_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         q_write_q       <= q_write_d;
         q_write_value_q <= q_write_value_d;
         q_pop_q         <= q_pop_d;
         q_peek_q        <= q_peek_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.q_write       = q_write_q;
   assign bus.q_pop         = q_pop_q;
   assign bus.q_peek        = q_peek_q;
   assign bus.q_write_value = q_write_value_q;
   assign bus.count         = count_q;
endmodule

// File: tb/tb_queue_client.sv
// Directed bench for queue_client with a show-ahead queue model and a handshake monitor.
// Build with QUEUE_CLIENT_PEEK_EN defined to cover the consume-on-accept variant.
module tb_queue_client;
   localparam int DATA_W   = 16;
   localparam int DEPTH    = 16;
   localparam int READ_LAT = 1;
`ifdef QUEUE_CLIENT_PEEK_EN
   localparam bit PEEK = 1'b1;
`else
   localparam bit PEEK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   queue_client_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   queue_client #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Show-ahead queue: q_read_value always presents the head word.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [3:0]        wr_ptr, rd_ptr;
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (bus.q_write) begin
            mem[wr_ptr] <= bus.q_write_value;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (bus.q_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   assign bus.q_read_value = mem[rd_ptr];

   logic [DATA_W-1:0] got[$];
   time               got_t[$];
   int n_pop, n_peek, max_count;
   int collisions = 0;
   int errors = 0;
   int checks = 0;

   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            got_t.push_back($time);
         end
         if (bus.q_pop)  n_pop++;
         if (bus.q_peek) n_peek++;
         if (bus.q_write && (bus.q_pop || bus.q_peek)) collisions++;
         if (bus.q_pop && bus.q_peek) collisions++;
         if (int'(bus.count) > max_count) max_count = int'(bus.count);
      end
   end

   function automatic logic [DATA_W-1:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 'x;
   endfunction

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      got_t.delete();
      n_pop = 0;
      n_peek = 0;
      max_count = 0;
   endtask

   task automatic push(input logic [DATA_W-1:0] v);
      bus.in_data  = v;
      bus.in_valid = 1'b1;
      #1;
      for (int i = 0; i < 50 && !bus.in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_accept data=%h in_ready=%b expected 1", v, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int i = 0; i < budget && got.size() < n; i++) @(negedge clk);
      checks++;
      if (got.size() < n) begin
         errors++;
         $display("FAIL wait_out got=%0d words expected %0d", got.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hAAAA;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks += 8;
      if (bus.in_ready !== 1'b0)     begin errors++; $display("FAIL rst_in_ready got=%b exp 0", bus.in_ready); end
      if (bus.out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid got=%b exp 0", bus.out_valid); end
      if (bus.out_data !== '0)       begin errors++; $display("FAIL rst_out_data got=%h exp 0", bus.out_data); end
      if (bus.q_write !== 1'b0)      begin errors++; $display("FAIL rst_q_write got=%b exp 0", bus.q_write); end
      if (bus.q_pop !== 1'b0)        begin errors++; $display("FAIL rst_q_pop got=%b exp 0", bus.q_pop); end
      if (bus.q_peek !== 1'b0)       begin errors++; $display("FAIL rst_q_peek got=%b exp 0", bus.q_peek); end
      if (bus.q_write_value !== '0)  begin errors++; $display("FAIL rst_q_write_value got=%h exp 0", bus.q_write_value); end
      if (bus.count !== '0)          begin errors++; $display("FAIL rst_count got=%0d exp 0", bus.count); end
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b exp 1", bus.in_ready); end
   endtask

   task automatic test_fifo_order();
      logic [DATA_W-1:0] exp_w [3];
      exp_w = '{16'h0001, 16'h0002, 16'h0003};
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) push(exp_w[i]);
      wait_out(3, 100);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_at(i) !== exp_w[i]) begin errors++; $display("FAIL fifo_word%0d got=%h exp %h", i, got_at(i), exp_w[i]); end
      end
      checks += 3;
      if (bus.count !== '0) begin errors++; $display("FAIL fifo_count_end got=%0d exp 0", bus.count); end
      if (n_pop != 3)       begin errors++; $display("FAIL fifo_pops got=%0d exp 3", n_pop); end
      if (max_count > 3 || max_count < 1) begin errors++; $display("FAIL fifo_peak got=%0d exp 1..3", max_count); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_fill();
      int n_acc = PEEK ? 16 : 17;
      int held = 0;
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < n_acc; i++) push(16'h0100 + 16'(i));
      #1;
      checks++;
      if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp 16", bus.count); end
      bus.in_data  = 16'h0100 + 16'(n_acc);
      bus.in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (bus.in_ready) held++;
      end
      checks++;
      if (held != 0) begin errors++; $display("FAIL fill_held in_ready_cycles=%0d exp 0", held); end
      bus.out_ready = 1'b1;
      push(16'h0100 + 16'(n_acc));
      wait_out(n_acc + 1, 400);
      for (int i = 0; i <= n_acc; i++) begin
         checks++;
         if (got_at(i) !== 16'h0100 + 16'(i)) begin
            errors++;
            $display("FAIL fill_word%0d got=%h exp %h", i, got_at(i), 16'h0100 + 16'(i));
         end
      end
      repeat (4) @(negedge clk);
      checks++;
      if (bus.count !== '0) begin errors++; $display("FAIL fill_count_end got=%0d exp 0", bus.count); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_hold();
      int p0, k0;
      int bad = 0;
      do_reset();
      bus.out_ready = 1'b0;
      push(16'h1234);
      for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp 1", bus.out_valid); end
      p0 = n_pop;
      k0 = n_peek;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234) bad++;
      end
      checks += 4;
      if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp 0", bad); end
      if (n_pop != p0 || n_peek != k0) begin
         errors++;
         $display("FAIL hold_strobes pop=%0d peek=%0d exp pop=%0d peek=%0d", n_pop, n_peek, p0, k0);
      end
      if (p0 != (PEEK ? 0 : 1)) begin errors++; $display("FAIL hold_pop_issue got=%0d exp %0d", p0, PEEK ? 0 : 1); end
      if (k0 != (PEEK ? 1 : 0)) begin errors++; $display("FAIL hold_peek_issue got=%0d exp %0d", k0, PEEK ? 1 : 0); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks += 2;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp 0", bus.out_valid); end
      if (bus.count !== '0)       begin errors++; $display("FAIL hold_release_count got=%0d exp 0", bus.count); end
   endtask

   task automatic test_collision();
      logic [DATA_W-1:0] exp_q[$];
      int mism = 0;
      do_reset();
      bus.out_ready = 1'b0;
      push(16'h00A1);
      bus.in_data  = 16'h00B2;
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL coll_in_ready got=%b exp 0", bus.in_ready); end
      @(negedge clk);
      checks += 2;
      if ((PEEK ? bus.q_peek : bus.q_pop) !== 1'b1) begin
         errors++;
         $display("FAIL coll_read_strobe pop=%b peek=%b exp strobe 1", bus.q_pop, bus.q_peek);
      end
      if (bus.q_write !== 1'b0) begin errors++; $display("FAIL coll_q_write got=%b exp 0", bus.q_write); end
      push(16'h00B2);
      exp_q = '{16'h00A1, 16'h00B2};
      for (int c = 0; c < 1000; c++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = 16'($urandom);
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_out(exp_q.size(), 2000);
      for (int i = 0; i < exp_q.size(); i++) if (got_at(i) !== exp_q[i]) mism++;
      checks += 2;
      if (mism != 0 || got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_order mismatches=%0d got=%0d words exp %0d words", mism, got.size(), exp_q.size());
      end
      if (collisions != 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp 0", collisions); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.out_ready = 1'b0;
      push(16'h00C1);
      push(16'h00C2);
      push(16'h00C3);
      for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
      bus.out_ready = 1'b1;
      wait_out(3, 50);
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (i >= got_t.size() || got_t[i] - got_t[i-1] != (READ_LAT + 2) * 10) begin
            errors++;
            $display("FAIL b2b_gap%0d got=%0t exp %0d", i, (i < got_t.size()) ? got_t[i] - got_t[i-1] : 0, (READ_LAT + 2) * 10);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_peek();
      do_reset();
      bus.out_ready = 1'b0;
      push(16'hBEEF);
      for (int i = 0; i < 10 && bus.q_peek !== 1'b1; i++) @(negedge clk);
      checks += 2;
      if (bus.q_peek !== 1'b1) begin errors++; $display("FAIL peek_strobe got=%b exp 1", bus.q_peek); end
      if (bus.count !== 5'd1)  begin errors++; $display("FAIL peek_count_issue got=%0d exp 1", bus.count); end
      for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) @(negedge clk);
      checks++;
      if (bus.count !== 5'd1) begin errors++; $display("FAIL peek_count_hold got=%0d exp 1", bus.count); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h7777;
      #1;
      checks += 4;
      if (bus.q_pop !== 1'b1)    begin errors++; $display("FAIL peek_pop got=%b exp 1", bus.q_pop); end
      if (bus.count !== '0)      begin errors++; $display("FAIL peek_count_pop got=%0d exp 0", bus.count); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL peek_in_ready got=%b exp 0", bus.in_ready); end
      if (got_at(0) !== 16'hBEEF) begin errors++; $display("FAIL peek_data got=%h exp beef", got_at(0)); end
      bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_rd_wait();
      do_reset();
      bus.out_ready = 1'b0;
      push(16'h5A5A);
      for (int i = 0; i < 10 && !(bus.q_pop || bus.q_peek); i++) @(negedge clk);
      checks++;
      if (!(bus.q_pop || bus.q_peek)) begin errors++; $display("FAIL rdw_strobe pop=%b peek=%b exp one high", bus.q_pop, bus.q_peek); end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks += 4;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rdw_out_valid got=%b exp 0", bus.out_valid); end
      if (bus.out_data !== '0)    begin errors++; $display("FAIL rdw_out_data got=%h exp 0", bus.out_data); end
      if (bus.count !== '0)       begin errors++; $display("FAIL rdw_count got=%0d exp 0", bus.count); end
      if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rdw_in_ready got=%b exp 0", bus.in_ready); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rdw_after_valid got=%b exp 0", bus.out_valid); end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_fifo_order();
      test_fill();
      test_hold();
      test_collision();
      test_back_to_back();
      if (PEEK) test_peek();
      test_reset_rd_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
